// File: rtl/vram_line_fetcher.sv
// Port-B line fetcher: walks VRAM with set-address / read / increment strobes
// over the shared tri-state bus and queues the words in a fall-through FIFO.
module vram_line_fetcher #(
   parameter int          DEPTH  = 8,
   parameter logic [15:0] STRIDE = 16'd1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [15:0]                  base_addr,
   input  logic [15:0]                  word_count,
   output logic                         busy,
   output logic                         done,
   inout  wire  [15:0]                  data_bus_infr,
   output logic                         set_address_b,
   output logic                         set_address_b_incr,
   output logic                         read_b,
   output logic [15:0]                  pix_data,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SET_ADDR = 3'd1,
      S_READ     = 3'd2,
      S_INCR     = 3'd3,
      S_WAIT     = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t         state_r;
   state_t         next_state_s;
   logic [15:0]    remaining_r;

   logic           busy_s, done_s, set_s, incr_s, read_s, drive_en_s;
   logic [15:0]    drive_val_s;
   logic           busy_r, done_r, set_r, incr_r, read_r, drive_en_r;
   logic [15:0]    drive_val_r;

   logic [15:0]    mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]  level_r, level_next_s;
   logic           pix_valid_r;
   logic           push_s, pop_s, full_s;

   assign full_s = (level_r == FULL_LEVEL);
   assign push_s = (state_r == S_READ);
   assign pop_s  = pix_valid_r & pix_ready;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; the full test uses the level at the start of the cycle
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               next_state_s = (word_count == 16'd0) ? S_DONE : S_SET_ADDR;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_SET_ADDR, S_INCR, S_WAIT: begin
            if (full_s) begin
               next_state_s = S_WAIT;
            end else begin
               next_state_s = S_READ;
            end
         end
         S_READ: begin
            if (remaining_r == 16'd1) begin
               next_state_s = S_DONE;
            end else begin
               next_state_s = S_INCR;
            end
         end
         S_DONE:  next_state_s = S_IDLE;
         default: next_state_s = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every strobe leaves a flop
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      set_s       = 1'b0;
      incr_s      = 1'b0;
      read_s      = 1'b0;
      drive_en_s  = 1'b0;
      drive_val_s = 16'd0;
      case (next_state_s)
         S_SET_ADDR: begin
            // SET_ADDR is only reached from IDLE, i.e. while base_addr is being captured
            busy_s      = 1'b1;
            set_s       = 1'b1;
            drive_en_s  = 1'b1;
            drive_val_s = base_addr;
         end
         S_READ: begin
            busy_s = 1'b1;
            read_s = 1'b1;
         end
         S_INCR: begin
            busy_s      = 1'b1;
            incr_s      = 1'b1;
            drive_en_s  = 1'b1;
            drive_val_s = STRIDE;
         end
         S_WAIT:  busy_s = 1'b1;
         S_DONE:  done_s = 1'b1;
         S_IDLE:  busy_s = 1'b0;
         default: busy_s = 1'b0;
      endcase
   end

   // Registered outputs and bus drive
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         set_r       <= 1'b0;
         incr_r      <= 1'b0;
         read_r      <= 1'b0;
         drive_en_r  <= 1'b0;
         drive_val_r <= 16'd0;
      end else begin
         busy_r      <= busy_s;
         done_r      <= done_s;
         set_r       <= set_s;
         incr_r      <= incr_s;
         read_r      <= read_s;
         drive_en_r  <= drive_en_s;
         drive_val_r <= drive_val_s;
      end
   end

   // Remaining-word counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remaining_r <= 16'd0;
      end else if (state_r == S_IDLE && start) begin
         remaining_r <= word_count;
      end else if (state_r == S_READ) begin
         remaining_r <= remaining_r - 16'd1;
      end else begin
         remaining_r <= remaining_r;
      end
   end

   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LW'(1);
         2'b01:   level_next_s = level_r - LW'(1);
         default: level_next_s = level_r;
      endcase
   end

   // FIFO pointers, level and valid flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         level_r     <= '0;
         pix_valid_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         level_r     <= level_next_s;
         pix_valid_r <= (level_next_s != '0);
      end
   end

   // FIFO storage: the bus word is captured at the edge closing a READ cycle
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_bus_infr;
      end
   end

   assign data_bus_infr      = drive_en_r ? drive_val_r : 16'hzzzz;
   assign busy               = busy_r;
   assign done               = done_r;
   assign set_address_b      = set_r;
   assign set_address_b_incr = incr_r;
   assign read_b             = read_r;
   assign pix_data           = mem_r[rd_ptr_r];
   assign pix_valid          = pix_valid_r;
   assign fifo_level         = level_r;

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Directed bench for vram_line_fetcher with a simple VRAM model returning addr+1000.
module tb_vram_line_fetcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = 16'd0;
   logic [15:0] word_count = 16'd0;
   logic        pix_ready = 1'b0;

   wire  [15:0] bus0, bus1;
   logic        busy0, done0, set0, incr0, read0, pv0;
   logic        busy1, done1, set1, incr1, read1, pv1;
   logic [15:0] pd0, pd1;
   logic [3:0]  lvl0, lvl1;
   logic [15:0] vaddr0 = 16'd0, vaddr1 = 16'd0;

   int n_cmp = 0, n_err = 0;

   // event / data logs written by the monitor
   int          n_ev0 = 0, n_log0 = 0, n_log1 = 0;
   int          n_rd0 = 0, n_rd1 = 0, n_dn0 = 0, n_dn1 = 0, n_busy0 = 0, n_multi = 0;
   int          ev_k0 [0:255];
   logic [15:0] ev_v0 [0:255];
   logic [15:0] log0  [0:255];
   logic [15:0] log1  [0:255];

   int b_ev0, b_log0, b_log1, b_rd0, b_rd1, b_dn0, b_dn1, b_busy0;

   always #5 clk = ~clk;

   vram_line_fetcher #(.DEPTH(8), .STRIDE(16'd1)) u0 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy0), .done(done0), .data_bus_infr(bus0), .set_address_b(set0),
      .set_address_b_incr(incr0), .read_b(read0), .pix_data(pd0), .pix_valid(pv0),
      .pix_ready(pix_ready), .fifo_level(lvl0));

   vram_line_fetcher #(.DEPTH(8), .STRIDE(16'd2)) u1 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
      .busy(busy1), .done(done1), .data_bus_infr(bus1), .set_address_b(set1),
      .set_address_b_incr(incr1), .read_b(read1), .pix_data(pd1), .pix_valid(pv1),
      .pix_ready(pix_ready), .fifo_level(lvl1));

   assign bus0 = read0 ? (vaddr0 + 16'd1000) : 16'hzzzz;
   assign bus1 = read1 ? (vaddr1 + 16'd1000) : 16'hzzzz;

   // VRAM port-B address model
   always @(posedge clk) begin
      if (set0) vaddr0 <= bus0;
      else if (incr0) vaddr0 <= vaddr0 + bus0;
      if (set1) vaddr1 <= bus1;
      else if (incr1) vaddr1 <= vaddr1 + bus1;
   end

   // Monitor: strobe events, pops, counters
   always @(posedge clk) begin
      if ((32'(set0) + 32'(incr0) + 32'(read0)) > 1 || (32'(set1) + 32'(incr1) + 32'(read1)) > 1)
         n_multi <= n_multi + 1;
      if (n_ev0 < 256) begin
         if (set0) begin
            ev_k0[n_ev0] <= 1; ev_v0[n_ev0] <= bus0; n_ev0 <= n_ev0 + 1;
         end else if (read0) begin
            ev_k0[n_ev0] <= 2; ev_v0[n_ev0] <= 16'd0; n_ev0 <= n_ev0 + 1;
         end else if (incr0) begin
            ev_k0[n_ev0] <= 3; ev_v0[n_ev0] <= bus0; n_ev0 <= n_ev0 + 1;
         end
      end
      if (pv0 && pix_ready && n_log0 < 256) begin log0[n_log0] <= pd0; n_log0 <= n_log0 + 1; end
      if (pv1 && pix_ready && n_log1 < 256) begin log1[n_log1] <= pd1; n_log1 <= n_log1 + 1; end
      if (read0) n_rd0 <= n_rd0 + 1;
      if (read1) n_rd1 <= n_rd1 + 1;
      if (done0) n_dn0 <= n_dn0 + 1;
      if (done1) n_dn1 <= n_dn1 + 1;
      if (busy0) n_busy0 <= n_busy0 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      b_ev0 = n_ev0; b_log0 = n_log0; b_log1 = n_log1; b_rd0 = n_rd0; b_rd1 = n_rd1;
      b_dn0 = n_dn0; b_dn1 = n_dn1; b_busy0 = n_busy0;
   endtask

   initial begin
      int exp_k [8];
      int exp_v [8];
      exp_k = '{1, 2, 3, 2, 3, 2, 3, 2};
      exp_v = '{100, 0, 1, 0, 1, 0, 1, 0};

      // async reset before any clock edge
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_strobes", 32'({set0, incr0, read0}), 32'd0);
      chk("rst_valid", 32'(pv0), 32'd0);
      chk("rst_level", 32'(lvl0), 32'd0);
      #4 reset = 1'b1;
      snap();
      tick(10);
      chk("idle_no_strobes", 32'(n_ev0 - b_ev0), 32'd0);
      chk("idle_no_busy", 32'(n_busy0 - b_busy0), 32'd0);

      // basic fetch: base 100, 4 words
      snap();
      base_addr = 16'd100; word_count = 16'd4; pix_ready = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("basic_set_k1", 32'(set0), 32'd1);
      chk("basic_bus_k1", 32'(bus0), 32'd100);
      chk("basic_busy_k1", 32'(busy0), 32'd1);
      tick(1);
      chk("basic_read_k2", 32'(read0), 32'd1);
      chk("basic_novalid_k2", 32'(pv0), 32'd0);
      tick(1);
      chk("basic_valid_k3", 32'(pv0), 32'd1);
      chk("basic_head_k3", 32'(pd0), 32'd1100);
      tick(10);
      chk("basic_nev", 32'(n_ev0 - b_ev0), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("basic_ev_kind", 32'(ev_k0[b_ev0 + i]), 32'(exp_k[i]));
         chk("basic_ev_val", 32'(ev_v0[b_ev0 + i]), 32'(exp_v[i]));
      end
      chk("basic_nlog", 32'(n_log0 - b_log0), 32'd4);
      for (int i = 0; i < 4; i++) chk("basic_data", 32'(log0[b_log0 + i]), 32'(1100 + i));
      chk("basic_busy_cycles", 32'(n_busy0 - b_busy0), 32'd8);
      chk("basic_done_pulses", 32'(n_dn0 - b_dn0), 32'd1);

      // backpressure: 12 words into depth 8
      snap();
      base_addr = 16'd300; word_count = 16'd12; pix_ready = 1'b0; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(40);
      chk("bp_reads_stalled", 32'(n_rd0 - b_rd0), 32'd8);
      chk("bp_level_full", 32'(lvl0), 32'd8);
      chk("bp_busy_wait", 32'(busy0), 32'd1);
      chk("bp_no_strobes", 32'({set0, incr0, read0}), 32'd0);
      chk("bp_head", 32'(pd0), 32'd1300);
      pix_ready = 1'b1;
      tick(40);
      chk("bp_reads_total", 32'(n_rd0 - b_rd0), 32'd12);
      chk("bp_nlog", 32'(n_log0 - b_log0), 32'd12);
      for (int i = 0; i < 12; i++) chk("bp_data", 32'(log0[b_log0 + i]), 32'(1300 + i));
      chk("bp_done_pulses", 32'(n_dn0 - b_dn0), 32'd1);
      chk("bp_level_empty", 32'(lvl0), 32'd0);

      // zero length
      snap();
      base_addr = 16'd50; word_count = 16'd0; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("zero_done_k1", 32'(done0), 32'd1);
      chk("zero_busy_k1", 32'(busy0), 32'd0);
      tick(1);
      chk("zero_done_k2", 32'(done0), 32'd0);
      tick(4);
      chk("zero_no_bus", 32'(n_ev0 - b_ev0), 32'd0);
      chk("zero_no_busy", 32'(n_busy0 - b_busy0), 32'd0);
      chk("zero_valid", 32'(pv0), 32'd0);

      // stride 2 instance; stray start during fetch
      snap();
      base_addr = 16'd200; word_count = 16'd3; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      base_addr = 16'd500; word_count = 16'd5; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(12);
      chk("stride_nlog", 32'(n_log1 - b_log1), 32'd3);
      for (int i = 0; i < 3; i++) chk("stride_data", 32'(log1[b_log1 + i]), 32'(1200 + 2 * i));
      chk("stride_reads", 32'(n_rd1 - b_rd1), 32'd3);
      chk("stride_done", 32'(n_dn1 - b_dn1), 32'd1);

      // reset mid-fetch after second READ
      snap();
      base_addr = 16'd400; word_count = 16'd6; pix_ready = 1'b0; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      chk("mid_reads_before", 32'(n_rd0 - b_rd0), 32'd2);
      #2 reset = 1'b0;
      #1;
      chk("mid_busy", 32'(busy0), 32'd0);
      chk("mid_strobes", 32'({set0, incr0, read0}), 32'd0);
      chk("mid_valid", 32'(pv0), 32'd0);
      chk("mid_level", 32'(lvl0), 32'd0);
      tick(1);
      reset = 1'b1;
      tick(1);
      snap();
      base_addr = 16'd600; word_count = 16'd2; pix_ready = 1'b1; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      chk("post_nlog", 32'(n_log0 - b_log0), 32'd2);
      chk("post_data0", 32'(log0[b_log0]), 32'd1600);
      chk("post_data1", 32'(log0[b_log0 + 1]), 32'd1601);
      chk("post_done", 32'(n_dn0 - b_dn0), 32'd1);
      chk("one_strobe_max", 32'(n_multi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
